alu_arbiter: RTL and testbench

- Shares the single combinational ALU (integer ADD/SUB/SLT/SRL, FP FCLASS/FSUB/FMUL/FCVTWS) between two requesters, e.g. the core execute stage and the FP/test path.
- Arbitrates round-robin and registers the operands onto the ALU inputs.
- Holds the op for its execution latency: 1 cycle integer, FP_LAT cycles FP. Then returns the result to the owning requester over a valid/ready response channel and counts overflow events.

---
 rtl/alu_arbiter_if.sv | 38 +++
 rtl/alu_arbiter.sv | 89 ++++++++
 tb/tb_alu_arbiter.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response/ALU bundle between two requesters, the arbiter and the shared ALU
// Parameters: DATA_WIDTH operand/result width, OVF_CNT_W overflow counter width.
// slave modport (arbiter): takes req*_valid/op/a/b, rsp*_ready, alu_data/alu_overflow;
//   drives req*_ready, rsp*_valid, rsp_data, rsp_overflow, alu_op/a/b, busy, ovf_cnt.
// master modport: the mirror image, for the requester/ALU side.
interface alu_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int OVF_CNT_W  = 8
);
    logic                  req0_valid, req1_valid;
    logic                  req0_ready, req1_ready;
    logic [4:0]            req0_op, req1_op;
    logic [DATA_WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic                  rsp0_valid, rsp1_valid;
    logic                  rsp0_ready, rsp1_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_overflow;
    logic [4:0]            alu_op;
    logic [DATA_WIDTH-1:0] alu_a, alu_b;
    logic [DATA_WIDTH-1:0] alu_data;
    logic                  alu_overflow;
    logic                  busy;
    logic [OVF_CNT_W-1:0]  ovf_cnt;

    modport slave (
        input  req0_valid, req1_valid, req0_op, req1_op, req0_a, req0_b, req1_a, req1_b,
               rsp0_ready, rsp1_ready, alu_data, alu_overflow,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rsp_overflow,
               alu_op, alu_a, alu_b, busy, ovf_cnt
    );

    modport master (
        output req0_valid, req1_valid, req0_op, req1_op, req0_a, req0_b, req1_a, req1_b,
               rsp0_ready, rsp1_ready, alu_data, alu_overflow,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rsp_overflow,
               alu_op, alu_a, alu_b, busy, ovf_cnt
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters with registered operands
// Ports: clk (rising edge), rst (synchronous active-high), bus (alu_arbiter_if.slave).
// Parameters: DATA_WIDTH, FP_LAT (EXEC cycles for ops 4..7, 1..15), OVF_CNT_W.
// Macro ALU_ARB_FIXED_PRIO_EN: when defined requester 0 always wins ties; otherwise round-robin.
module alu_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int FP_LAT     = 3,
    parameter int OVF_CNT_W  = 8
) (
    input logic          clk,
    input logic          rst,
    alu_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [3:0] FP_INIT = 4'(FP_LAT - 1);

    logic [1:0]            state;
    logic                  owner, last_grant, grant, accept, rsp_hs, res_ovf;
    logic [4:0]            op, op_in;
    logic [DATA_WIDTH-1:0] a, b, result;
    logic [3:0]            lat_cnt;
    logic [OVF_CNT_W-1:0]  ovf_cnt;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign grant = !bus.req0_valid;
`else
    // On a tie the requester that did not win last time gets the ALU.
    assign grant = (bus.req0_valid && bus.req1_valid) ? !last_grant : !bus.req0_valid;
`endif

    assign bus.req0_ready = state == IDLE && !grant && bus.req0_valid;
    assign bus.req1_ready = state == IDLE && grant && bus.req1_valid;
    assign accept         = bus.req0_ready || bus.req1_ready;
    assign op_in          = grant ? bus.req1_op : bus.req0_op;
    assign rsp_hs         = state == RESP && (owner ? bus.rsp1_ready : bus.rsp0_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            op         <= '0;
            a          <= '0;
            b          <= '0;
            lat_cnt    <= '0;
            result     <= '0;
            res_ovf    <= 1'b0;
            ovf_cnt    <= '0;
        end else begin
            if (accept) begin
                state   <= EXEC;
                owner   <= grant;
                op      <= op_in;
                a       <= grant ? bus.req1_a : bus.req0_a;
                b       <= grant ? bus.req1_b : bus.req0_b;
                // Ops 4..7 are the FP group; everything else completes in one EXEC cycle.
                lat_cnt <= op_in[4:2] == 3'b001 ? FP_INIT : 4'd0;
            end
            if (state == EXEC) begin
                if (lat_cnt != 4'd0) begin
                    lat_cnt <= lat_cnt - 4'd1;
                end else begin
                    result  <= bus.alu_data;
                    res_ovf <= bus.alu_overflow;
                    state   <= RESP;
                end
            end
            if (rsp_hs) begin
                last_grant <= owner;
                if (res_ovf && !(&ovf_cnt))
                    ovf_cnt <= ovf_cnt + OVF_CNT_W'(1);
                state <= IDLE;
            end
        end
    end

    // Operand registers only change on accept, so the ALU inputs hold outside EXEC.
    assign bus.alu_op       = op;
    assign bus.alu_a        = a;
    assign bus.alu_b        = b;
    assign bus.rsp0_valid   = state == RESP && !owner;
    assign bus.rsp1_valid   = state == RESP && owner;
    assign bus.rsp_data     = result;
    assign bus.rsp_overflow = res_ovf;
    assign bus.busy         = state != IDLE;
    assign bus.ovf_cnt      = ovf_cnt;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter with a behavioural ALU
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;

    alu_arbiter_if #(.DATA_WIDTH(32), .OVF_CNT_W(8)) bus ();

    alu_arbiter #(.DATA_WIDTH(32), .FP_LAT(3), .OVF_CNT_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Stand-in ALU: integer ops computed exactly, FP ops return a tagged constant.
    logic [31:0] sum, dif;
    always_comb begin
        sum = bus.alu_a + bus.alu_b;
        dif = bus.alu_a - bus.alu_b;
        bus.alu_data = 32'h0;
        bus.alu_overflow = 1'b0;
        case (bus.alu_op)
            5'd0: begin
                bus.alu_data = sum;
                bus.alu_overflow = (bus.alu_a[31] == bus.alu_b[31]) && (sum[31] != bus.alu_a[31]);
            end
            5'd1: begin
                bus.alu_data = dif;
                bus.alu_overflow = (bus.alu_a[31] != bus.alu_b[31]) && (dif[31] != bus.alu_a[31]);
            end
            5'd2: bus.alu_data = {31'h0, $signed(bus.alu_a) < $signed(bus.alu_b)};
            5'd3: bus.alu_data = bus.alu_a >> bus.alu_b[4:0];
            5'd4, 5'd5, 5'd6, 5'd7: bus.alu_data = 32'hC0DE0000 | {27'h0, bus.alu_op};
            default: bus.alu_data = 32'h0;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input int n, input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        int k = 0;
        @(posedge clk); #1;
        if (n == 0) begin
            bus.req0_valid = 1'b1; bus.req0_op = o; bus.req0_a = x; bus.req0_b = y;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_op = o; bus.req1_a = x; bus.req1_b = y;
        end
        @(negedge clk);
        while (!(n != 0 ? bus.req1_ready : bus.req0_ready) && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("accept", n != 0 ? bus.req1_ready : bus.req0_ready, 1'b1);
        @(posedge clk); #1;
        if (n == 0) bus.req0_valid = 1'b0;
        else bus.req1_valid = 1'b0;
    endtask

    task automatic serve(input int n, input logic [31:0] d, input logic o);
        int k = 0;
        @(negedge clk);
        while (!(n != 0 ? bus.rsp1_valid : bus.rsp0_valid) && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("rsp_valid", n != 0 ? bus.rsp1_valid : bus.rsp0_valid, 1'b1);
        chk("rsp_other", n != 0 ? bus.rsp0_valid : bus.rsp1_valid, 1'b0);
        chk("rsp_data", bus.rsp_data, d);
        chk("rsp_ovf", bus.rsp_overflow, o);
        if (n == 0) bus.rsp0_ready = 1'b1;
        else bus.rsp1_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int g, r;
        logic exp_g;
        bus.req0_valid = 0; bus.req1_valid = 0;
        bus.req0_op = 0; bus.req1_op = 0;
        bus.req0_a = 0; bus.req0_b = 0; bus.req1_a = 0; bus.req1_b = 0;
        bus.rsp0_ready = 0; bus.rsp1_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_rsp0", bus.rsp0_valid, 1'b0);
        chk("rst_rsp1", bus.rsp1_valid, 1'b0);
        chk("rst_ovf_cnt", bus.ovf_cnt, 8'h00);
        chk("rst_alu_op", bus.alu_op, 5'd0);
        chk("rst_alu_a", bus.alu_a, 32'h0);
        chk("rst_rsp_data", bus.rsp_data, 32'h0);

        // Overflowing ADD from requester 0 right out of reset.
        @(posedge clk); #1;
        rst = 1'b0;
        bus.req0_valid = 1; bus.req0_op = 5'd0; bus.req0_a = 32'h7FFFFFFF; bus.req0_b = 32'h1;
        @(negedge clk);
        chk("t1_ready0", bus.req0_ready, 1'b1);
        chk("t1_ready1", bus.req1_ready, 1'b0);
        @(posedge clk); #1;
        bus.req0_valid = 0;
        @(negedge clk);
        chk("t1_busy", bus.busy, 1'b1);
        chk("t1_rsp_early", bus.rsp0_valid, 1'b0);
        @(negedge clk);
        chk("t1_rsp0_valid", bus.rsp0_valid, 1'b1);
        chk("t1_data", bus.rsp_data, 32'h80000000);
        chk("t1_ovf", bus.rsp_overflow, 1'b1);
        bus.rsp0_ready = 1;
        @(posedge clk); #1;
        bus.rsp0_ready = 0;
        @(negedge clk);
        chk("t1_ovf_cnt", bus.ovf_cnt, 8'h01);
        chk("t1_idle", bus.busy, 1'b0);

        // Round-robin with both requesters continuously valid.
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        bus.req0_valid = 1; bus.req0_op = 5'd1; bus.req0_a = 32'd5; bus.req0_b = 32'd3;
        bus.req1_valid = 1; bus.req1_op = 5'd2; bus.req1_a = 32'hFFFFFFFF; bus.req1_b = 32'd1;
        bus.rsp0_ready = 1; bus.rsp1_ready = 1;
        g = 0; r = 0; exp_g = 1'b0;
        for (int i = 0; i < 60 && r < 4; i++) begin
            @(negedge clk);
            if (bus.rsp0_valid) begin
                chk("rr_data0", bus.rsp_data, 32'd2);
                chk("rr_rsp1_excl", bus.rsp1_valid, 1'b0);
                r++;
            end else if (bus.rsp1_valid) begin
                chk("rr_data1", bus.rsp_data, 32'd1);
                r++;
            end
            if (g < 4 && (bus.req0_ready || bus.req1_ready)) begin
                chk("rr_grant", bus.req1_ready, exp_g);
                chk("rr_one_ready", bus.req0_ready && bus.req1_ready, 1'b0);
                exp_g = !exp_g;
                g++;
                if (g == 4) begin
                    @(posedge clk); #1;
                    bus.req0_valid = 0; bus.req1_valid = 0;
                end
            end
        end
        chk("rr_rsp_count", r, 4);
        @(posedge clk); #1;
        bus.rsp0_ready = 0; bus.rsp1_ready = 0;

        // FSUB on requester 1: three EXEC cycles with steady ALU inputs.
        issue(1, 5'd5, 32'h40000000, 32'h3F800000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("fp_alu_op", bus.alu_op, 5'd5);
            chk("fp_busy", bus.busy, 1'b1);
            chk("fp_rsp_early", bus.rsp1_valid, 1'b0);
        end
        @(negedge clk);
        chk("fp_rsp1_valid", bus.rsp1_valid, 1'b1);
        chk("fp_data", bus.rsp_data, 32'hC0DE0005);
        chk("fp_alu_hold", bus.alu_op, 5'd5);
        bus.rsp1_ready = 1;
        @(posedge clk); #1;
        bus.rsp1_ready = 0;
        @(negedge clk);
        chk("fp_idle", bus.busy, 1'b0);

        // Response backpressure while requester 1 waits.
        issue(0, 5'd3, 32'hF0, 32'd4);
        bus.req1_valid = 1; bus.req1_op = 5'd0; bus.req1_a = 32'd1; bus.req1_b = 32'd2;
        @(negedge clk);
        chk("bp_wait_exec", bus.req1_ready, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp0_held", bus.rsp0_valid, 1'b1);
            chk("bp_data_held", bus.rsp_data, 32'h0F);
            chk("bp_no_accept", bus.req1_ready, 1'b0);
        end
        bus.rsp0_ready = 1;
        @(posedge clk); #1;
        bus.rsp0_ready = 0;
        @(negedge clk);
        chk("bp_accept_after", bus.req1_ready, 1'b1);
        @(posedge clk); #1;
        bus.req1_valid = 0;
        serve(1, 32'd3, 1'b0);

        // Reset during FCLASS execution abandons the op.
        issue(1, 5'd4, 32'h1, 32'h0);
        @(negedge clk);
        chk("rs_busy", bus.busy, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rs_idle", bus.busy, 1'b0);
        chk("rs_ovf_cnt", bus.ovf_cnt, 8'h00);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rs_no_rsp", bus.rsp1_valid, 1'b0);
        end
        @(posedge clk); #1;
        bus.req0_valid = 1; bus.req0_op = 5'd0; bus.req0_a = 32'd1; bus.req0_b = 32'd1;
        bus.req1_valid = 1; bus.req1_op = 5'd0; bus.req1_a = 32'd2; bus.req1_b = 32'd2;
        @(negedge clk);
        chk("rs_grant0", bus.req0_ready, 1'b1);
        chk("rs_not1", bus.req1_ready, 1'b0);
        @(posedge clk); #1;
        bus.req0_valid = 0; bus.req1_valid = 0;
        serve(0, 32'd2, 1'b0);

        // Saturating overflow counter.
        for (int i = 0; i < 256; i++) begin
            issue(0, 5'd0, 32'h7FFFFFFF, 32'h1);
            serve(0, 32'h80000000, 1'b1);
            if (i == 0) begin
                @(negedge clk);
                chk("sat_first", bus.ovf_cnt, 8'h01);
            end
            if (i == 254) begin
                @(negedge clk);
                chk("sat_255", bus.ovf_cnt, 8'hFF);
            end
        end
        @(negedge clk);
        chk("sat_hold", bus.ovf_cnt, 8'hFF);

`ifdef ALU_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            bus.req0_valid = 1; bus.req0_op = 5'd0; bus.req0_a = 32'd1; bus.req0_b = 32'd1;
            bus.req1_valid = 1; bus.req1_op = 5'd0; bus.req1_a = 32'd2; bus.req1_b = 32'd2;
            @(negedge clk);
            chk("fix_ready0", bus.req0_ready, 1'b1);
            chk("fix_ready1", bus.req1_ready, 1'b0);
            @(posedge clk); #1;
            bus.req0_valid = 0; bus.req1_valid = 0;
            serve(0, 32'd2, 1'b0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
